// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared light encodings, phase codes and a sizing helper for the intersection controller.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t GREEN  = 3'b100;
  localparam light_t YELLOW = 3'b010;
  localparam light_t RED    = 3'b001;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    A_ALLRED = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    B_ALLRED = 3'd5,
    WALK     = 3'd6
  } phase_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor inputs and light outputs of the intersection, bundled for the controller.
// Handshake: none; every signal is a plain level that is valid every cycle.
interface traffic_phase_scheduler_if;
  logic                  Sa;
  logic                  Sb;
  logic                  ped_req;
  traffic_pkg::light_t   La;
  traffic_pkg::light_t   Lb;
  logic                  walk;
  traffic_pkg::phase_t   phase;

  modport master (
    output Sa, Sb, ped_req,
    input  La, Lb, walk, phase
  );

  modport slave (
    input  Sa, Sb, ped_req,
    output La, Lb, walk, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Per-phase cycle counter: clears on a phase change, otherwise counts up,
// optionally holding at a limit so long greens never wrap.
module phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         sat_en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!(sat_en && cnt >= limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street traffic light controller with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase is built when PED_WALK_EN is defined.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 12,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned WALK_TIME   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    traffic_phase_scheduler_if.slave bus
);

    localparam int unsigned T_MAX =
        max2(max2(max2(MIN_GREEN, MAX_GREEN), max2(YELLOW_TIME, ALLRED_TIME)), WALK_TIME);
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TIME - 1);
`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_TIME - 1);
`endif

    phase_t           state;
    phase_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             ped_pending;
    logic             demand_a;
    logic             demand_b;
    logic             is_green;

    phase_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next != state),
        .sat_en (is_green),
        .limit  (MAX_M1),
        .cnt    (cnt)
    );

`ifdef PED_WALK_EN
    logic next_b;

    // Clear on WALK entry dominates a same-cycle request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pending <= 1'b0;
        end else if (state_next == WALK && state != WALK) begin
            ped_pending <= 1'b0;
        end else if (bus.ped_req && state != WALK) begin
            ped_pending <= 1'b1;
        end
    end

    // Remembers which street should get green after a walk phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_b <= 1'b1;
        end else if (state == A_GREEN) begin
            next_b <= 1'b1;
        end else if (state == B_GREEN) begin
            next_b <= 1'b0;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign ped_pending    = 1'b0;
`endif

    assign demand_a = bus.Sa | ped_pending;
    assign demand_b = bus.Sb | ped_pending;
    assign is_green = (state == A_GREEN) || (state == B_GREEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= A_GREEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.La     = RED;
        bus.Lb     = RED;
        bus.walk   = 1'b0;
        bus.phase  = state;
        case (state)
            A_GREEN: begin
                bus.La = GREEN;
                if (cnt >= MIN_M1 && demand_b && (!bus.Sa || cnt == MAX_M1)) begin
                    state_next = A_YELLOW;
                end
            end
            A_YELLOW: begin
                bus.La = YELLOW;
                if (cnt == YELLOW_M1) state_next = A_ALLRED;
            end
            A_ALLRED: begin
                if (cnt == ALLRED_M1) state_next = ped_pending ? WALK : B_GREEN;
            end
            B_GREEN: begin
                bus.Lb = GREEN;
                if (cnt >= MIN_M1 && demand_a && (!bus.Sb || cnt == MAX_M1)) begin
                    state_next = B_YELLOW;
                end
            end
            B_YELLOW: begin
                bus.Lb = YELLOW;
                if (cnt == YELLOW_M1) state_next = B_ALLRED;
            end
            B_ALLRED: begin
                if (cnt == ALLRED_M1) state_next = ped_pending ? WALK : A_GREEN;
            end
`ifdef PED_WALK_EN
            WALK: begin
                bus.walk = 1'b1;
                if (cnt == WALK_M1) state_next = next_b ? B_GREEN : A_GREEN;
            end
`endif
            default: state_next = A_GREEN;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler; expectations adapt to PED_WALK_EN.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int W = 10;

  typedef struct {
    logic       sa;
    logic       sb;
    logic       ped;
    logic [2:0] ph;
    logic       wk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic logic [2:0] la_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b100;
      3'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] lb_of(input logic [2:0] ph);
    case (ph)
      3'd3:    return 3'b100;
      3'd4:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic void expect_state(input logic [2:0] ph, input logic wk);
    exp_q.push_back({la_of(ph), lb_of(ph), wk, ph});
  endfunction

  function automatic void add(input logic sa, input logic sb, input logic ped,
                              input logic [2:0] ph, input logic wk, input int count);
    vec_t v;
    v.sa = sa; v.sb = sb; v.ped = ped; v.ph = ph; v.wk = wk;
    for (int i = 0; i < count; i++) tbl.push_back(v);
  endfunction

  task automatic compare(input string name);
    logic [W-1:0] e;
    logic [W-1:0] a;
    n_checks++;
    a = {bus.La, bus.Lb, bus.walk, 3'(bus.phase)};
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry, got %b", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a === e) n_pass++;
      else $display("FAIL %s @%0t: got La=%b Lb=%b walk=%b phase=%0d, required La=%b Lb=%b walk=%b phase=%0d",
                    name, $time, a[9:7], a[6:4], a[3], a[2:0], e[9:7], e[6:4], e[3], e[2:0]);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    bus.Sa = v.sa;
    bus.Sb = v.sb;
    bus.ped_req = v.ped;
    expect_state(v.ph, v.wk);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", name, i + 1));
    tbl.delete();
  endtask

  task automatic do_reset(input logic sa, input logic sb);
    reset = 1'b0;
    bus.Sa = sa;
    bus.Sb = sb;
    bus.ped_req = 1'b0;
    @(posedge clk);
    #1;
    expect_state(3'd0, 1'b0);
    compare("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_state(3'd0, 1'b0);
    compare("reset_release");
  endtask

  initial begin
    bus.Sa = 1'b0;
    bus.Sb = 1'b0;
    bus.ped_req = 1'b0;

    // Test 1: only A has traffic, A green holds.
    do_reset(1'b1, 1'b0);
    add(1, 0, 0, 3'd0, 0, 50);
    run_tbl("a_only");

    // Test 2: minimum handover to B.
    do_reset(1'b0, 1'b1);
    add(0, 1, 0, 3'd0, 0, 3);
    add(0, 1, 0, 3'd1, 0, 2);
    add(0, 1, 0, 3'd2, 0, 1);
    add(0, 1, 0, 3'd3, 0, 4);
    run_tbl("min_handover");

    // Test 3: both contested, 12-cycle greens, 30-cycle period.
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      int p;
      logic [2:0] ph;
      p = k % 30;
      if (p < 12)       ph = 3'd0;
      else if (p < 14)  ph = 3'd1;
      else if (p == 14) ph = 3'd2;
      else if (p < 27)  ph = 3'd3;
      else if (p < 29)  ph = 3'd4;
      else              ph = 3'd5;
      add(1, 1, 0, ph, 0, 1);
    end
    run_tbl("max_green");

    // Test 4: one-cycle pedestrian request while A has steady traffic.
    do_reset(1'b1, 1'b0);
`ifdef PED_WALK_EN
    add(1, 0, 0, 3'd0, 0, 2);
    add(1, 0, 1, 3'd0, 0, 1);
    add(1, 0, 0, 3'd0, 0, 8);
    add(1, 0, 0, 3'd1, 0, 2);
    add(1, 0, 0, 3'd2, 0, 1);
    add(1, 0, 0, 3'd6, 1, 3);
    add(1, 0, 0, 3'd3, 0, 4);
    add(1, 0, 0, 3'd4, 0, 2);
    add(1, 0, 0, 3'd5, 0, 1);
    add(1, 0, 0, 3'd0, 0, 3);
`else
    add(1, 0, 0, 3'd0, 0, 2);
    add(1, 0, 1, 3'd0, 0, 1);
    add(1, 0, 0, 3'd0, 0, 24);
`endif
    run_tbl("ped_walk");

    // Test 5: async reset in the middle of B yellow with a walk pending.
    do_reset(1'b0, 1'b1);
    add(0, 1, 0, 3'd0, 0, 3);
    add(0, 1, 0, 3'd1, 0, 2);
    add(0, 1, 0, 3'd2, 0, 1);
    add(0, 1, 0, 3'd3, 0, 1);
    add(1, 0, 1, 3'd3, 0, 1);
    add(1, 0, 0, 3'd3, 0, 2);
    add(1, 0, 0, 3'd4, 0, 1);
    run_tbl("to_b_yellow");
    #2;
    reset = 1'b0;
    expect_state(3'd0, 1'b0);
    #1;
    compare("async_reset");
    @(negedge clk);
    reset = 1'b1;
    add(1, 0, 0, 3'd0, 0, 20);
    run_tbl("no_stale_walk");

    // Test 6: a one-cycle Sb pulse before minimum green is lost.
    do_reset(1'b0, 1'b0);
    add(0, 0, 0, 3'd0, 0, 1);
    add(0, 1, 0, 3'd0, 0, 1);
    add(0, 0, 0, 3'd0, 0, 20);
    run_tbl("lost_pulse");

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d expected entries unconsumed, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

- Sequences the two-street intersection lights `La`/`Lb` from the street sensors `Sa`/`Sb` and an optional pedestrian request.
- Enforces minimum and maximum green times, a timed yellow and an all-red clearance interval between greens.
- Replaces the bare sensor-driven light FSM as the controller that owns the intersection.

## Interface
- `MIN_GREEN`, default 4: minimum green length in cycles, ≥1.
- `MAX_GREEN`, default 12: green length cap when both streets are contested; `MIN_GREEN ≤ MAX_GREEN`.
- `YELLOW_TIME`, default 2: yellow length in cycles, ≥1.
- `ALLRED_TIME`, default 1: all-red clearance length in cycles, ≥1.
- `WALK_TIME`, default 3: pedestrian walk length in cycles, ≥1.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Sa` in 1: car present on street A.
- `Sb` in 1: car present on street B.
- `ped_req` in 1: pedestrian button, level, sampled every cycle.
- `La` out 3: street A light, one-hot: GREEN=3'b100, YELLOW=3'b010, RED=3'b001.
- `Lb` out 3: street B light, same encoding.
- `walk` out 1: pedestrian walk indicator.
- `phase` out 3: current state code (`phase_t`).

## Operation
- States and what each drives:
  - A_GREEN: `La`=G, `Lb`=R.
  - A_YELLOW: `La`=Y, `Lb`=R.
  - A_ALLRED: both R.
  - B_GREEN: `La`=R, `Lb`=G.
  - B_YELLOW: `La`=R, `Lb`=Y.
  - B_ALLRED: both R.
  - WALK: both R, `walk`=1.
- Outputs are decoded only from the state register (Moore). `walk`=1 only in WALK.
- A phase counter `cnt` clears to 0 on every state change and increments every cycle otherwise. In green states it saturates at `MAX_GREEN`-1.
- A timed state of length T lasts exactly T cycles: it exits on the edge that follows the cycle where `cnt`==T-1.
- `ped_pending` (1 bit):
  - Set on any cycle where `ped_req`=1.
  - Cleared on the edge that enters WALK; clear wins over set on that edge.
  - `ped_req` is ignored while in WALK.
- Exit from A_GREEN to A_YELLOW requires all of the following, evaluated combinationally in the current cycle:
  - `cnt` ≥ `MIN_GREEN`-1;
  - `demand_B` = `Sb` | `ped_pending`;
  - (`Sa`=0 | `cnt`==`MAX_GREEN`-1).
- B_GREEN exits the same way, with `Sa`/`Sb` swapped.
- With no cross demand, the current green holds indefinitely.
- Sensors are not latched. A pulse on `Sb` that ends before the decision cycle is lost.
- A_YELLOW runs for `YELLOW_TIME` cycles, then A_ALLRED.
- A_ALLRED runs for `ALLRED_TIME` cycles, then WALK if `ped_pending`, else B_GREEN.
- The B side mirrors this: B_YELLOW → B_ALLRED → WALK or A_GREEN.
- WALK runs for `WALK_TIME` cycles. It then goes to the green opposite the street that last held green, tracked by a 1-bit `next_b` register.

## Timing
- Reset (`reset`=0) takes effect immediately, without a clock edge:
  - state=A_GREEN, `cnt`=0, `ped_pending`=0, `next_b`=1;
  - `La`=3'b100, `Lb`=3'b001, `walk`=0, `phase`=A_GREEN code.
- Reset asserted mid-phase aborts that phase and forces the values above.
- Light changes appear in the same cycle as the state edge. There is no extra output register latency.
- Minimum green-to-green handover (A to B) is `MIN_GREEN`+`YELLOW_TIME`+`ALLRED_TIME` cycles. With defaults: B goes green at the 7th rising edge after reset release when `Sa`=0 and `Sb`=1.
- Both streets may never be non-RED in the same cycle. A green never follows a green without yellow and all-red in between.
- `cnt` width: `$clog2(max of all timing parameters)`+1 bits, unsigned, with no wrap in any state.

## Configuration
- `PED_WALK_EN` defined:
  - WALK state, `ped_pending` and `next_b` logic are present;
  - `ped_pending` counts as cross demand.
- `PED_WALK_EN` undefined:
  - WALK is unreachable and removed;
  - `ped_req` is ignored, `walk` is tied 0, and `demand_B`=`Sb` only;
  - `WALK_TIME` stays declared but is unused.

## Structure
- Package `traffic_pkg` holds:
  - `light_t` (3-bit) with constants GREEN, YELLOW, RED;
  - `phase_t` enum (3-bit): A_GREEN=0, A_YELLOW=1, A_ALLRED=2, B_GREEN=3, B_YELLOW=4, B_ALLRED=5, WALK=6.
- Sub-module `phase_timer` holds `cnt` with clear, increment and saturate-at-limit inputs. The FSM and output decode stay in the top module.

## Test plan
1. Reset, then `Sa`=1, `Sb`=0 for 50 cycles → `La`=100, `Lb`=001 throughout, `phase`=0.
2. Release reset with `Sa`=0, `Sb`=1 → `La`=100 for 4 cycles, 010 for 2, then both 001 for 1; `Lb`=100 at the 7th edge.
3. `Sa`=`Sb`=1 held → greens alternate, each lasting exactly 12 cycles; the full cycle period is 30 cycles.
4. `PED_WALK_EN` defined, `Sa`=1, `Sb`=0, one-cycle `ped_req` at cycle 2 → A green for 12 cycles, yellow 2, all-red 1, then `walk`=1 with both RED for 3 cycles, then B_GREEN. With the macro undefined: A stays green and `walk` stays 0.
5. Reset asserted mid B_YELLOW, between edges → `La`=100, `Lb`=001, `walk`=0 immediately; after release, a pending walk no longer occurs.
6. `Sa`=0, `Sb` pulsed for 1 cycle at `cnt`=1 only → no exit from A_GREEN; state remains A_GREEN.
